// File: rtl/vgaconsole_pkg.sv
// Shared types and constants for the VGA console terminal sequencer.
package vgaconsole_pkg;

    localparam int unsigned DEF_NUM_ROWS = 3;
    localparam int unsigned DEF_NUM_COLS = 10;
    localparam int unsigned ADDR_W       = 5;
    localparam int unsigned CHAR_W       = 7;
    localparam int unsigned BYTE_W       = 8;

    localparam logic [CHAR_W-1:0] DEF_BLANK_CHAR = 7'h20;

    localparam logic [BYTE_W-1:0] CH_LF     = 8'h0A;
    localparam logic [BYTE_W-1:0] CH_CR     = 8'h0D;
    localparam logic [BYTE_W-1:0] CH_BS     = 8'h08;
    localparam logic [BYTE_W-1:0] CH_FF     = 8'h0C;
    localparam logic [BYTE_W-1:0] PRINT_MIN = 8'h20;
    localparam logic [BYTE_W-1:0] PRINT_MAX = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SCROLL_COPY,
        ST_SCROLL_FILL,
        ST_CLEAR
    } state_t;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_ADVANCE,
        CUR_NEWLINE,
        CUR_CR,
        CUR_BACK,
        CUR_HOME,
        CUR_BOTTOM
    } cur_op_t;

    // True for bytes that are written to the screen as glyphs.
    function automatic logic is_printable(input logic [BYTE_W-1:0] b);
        return (b >= PRINT_MIN) && (b <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/vgaconsole_cursor.sv
// Cursor row/column registers with the editing operations the sequencer needs.
module vgaconsole_cursor
    import vgaconsole_pkg::*;
#(
    parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
    parameter int unsigned NUM_COLS = DEF_NUM_COLS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  cur_op_t                     op,
    output logic [$clog2(NUM_ROWS)-1:0] row,
    output logic [$clog2(NUM_COLS)-1:0] col,
    output logic                        scroll_needed,
    output logic                        at_last_col,
    output logic [ADDR_W-1:0]           addr
);

    localparam int unsigned ROW_W = $clog2(NUM_ROWS);
    localparam int unsigned COL_W = $clog2(NUM_COLS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    // Apply one cursor operation per cycle; CUR_NONE holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else begin
            case (op)
                CUR_ADVANCE: begin
                    if (col == LAST_COL) begin
                        col <= '0;
                        if (row != LAST_ROW) row <= row + ROW_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                CUR_NEWLINE: begin
                    col <= '0;
                    if (row != LAST_ROW) row <= row + ROW_W'(1);
                end
                CUR_CR: col <= '0;
                CUR_BACK: begin
                    if (col != '0) col <= col - COL_W'(1);
                end
                CUR_HOME: begin
                    row <= '0;
                    col <= '0;
                end
                CUR_BOTTOM: begin
                    row <= LAST_ROW;
                    col <= '0;
                end
                default: ;
            endcase
        end
    end

    assign scroll_needed = (row == LAST_ROW);
    assign at_last_col   = (col == LAST_COL);
    assign addr          = ADDR_W'(row) * ADDR_W'(NUM_COLS) + ADDR_W'(col);

endmodule

// File: rtl/vgaconsole_term_ctrl.sv
// Terminal sequencer for the VGA console text buffer: byte stream in, cursor,
// control codes, scroll/clear sequences, CPU-priority write-port arbitration.
// Optional macro VGACON_VBLANK_SYNC_EN: controller steps only execute during vblank.
module vgaconsole_term_ctrl
    import vgaconsole_pkg::*;
#(
    parameter int unsigned       NUM_ROWS   = DEF_NUM_ROWS,
    parameter int unsigned       NUM_COLS   = DEF_NUM_COLS,
    parameter logic [CHAR_W-1:0] BLANK_CHAR = DEF_BLANK_CHAR
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BYTE_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        host_we,
    input  logic [ADDR_W-1:0]           host_addr,
    input  logic [CHAR_W-1:0]           host_data,
    input  logic                        clear_req,
    input  logic                        vblank,
    output logic                        buf_we,
    output logic [ADDR_W-1:0]           buf_waddr,
    output logic [CHAR_W-1:0]           buf_wdata,
    output logic [ADDR_W-1:0]           buf_raddr,
    input  logic [CHAR_W-1:0]           buf_rdata,
    output logic [$clog2(NUM_ROWS)-1:0] cursor_row,
    output logic [$clog2(NUM_COLS)-1:0] cursor_col,
    output logic                        busy
);

    localparam int unsigned CELLS      = NUM_ROWS * NUM_COLS;
    localparam int unsigned COPY_CELLS = (NUM_ROWS - 1) * NUM_COLS;
    localparam logic [ADDR_W-1:0] COPY_LAST  = ADDR_W'(COPY_CELLS - 1);
    localparam logic [ADDR_W-1:0] FILL_LAST  = ADDR_W'(NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] FILL_BASE  = ADDR_W'(COPY_CELLS);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(NUM_COLS);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   idx, idx_n;
    logic [CHAR_W-1:0]   ch, ch_n;
    logic                adv, adv_n;
    logic                clear_pending, clear_pending_n;
    logic                clear_done;
    cur_op_t             cur_op;
    logic                step_ok;
    logic                step_we;
    logic [ADDR_W-1:0]   step_waddr;
    logic [CHAR_W-1:0]   step_wdata;
    logic [ADDR_W-1:0]   step_raddr;
    logic                accept;
    logic                scroll_needed;
    logic                at_last_col;
    logic [ADDR_W-1:0]   cur_addr;

    // A controller step runs only when the CPU is not using the write port.
`ifdef VGACON_VBLANK_SYNC_EN
    assign step_ok = ~host_we & vblank;
`else
    logic vblank_unused;
    assign vblank_unused = vblank;
    assign step_ok       = ~host_we;
`endif

    assign in_ready = (state == ST_IDLE) & ~clear_pending & ~clear_req;
    assign accept   = in_valid & in_ready;
    assign busy     = (state != ST_IDLE) | clear_pending;

    vgaconsole_cursor #(
        .NUM_ROWS (NUM_ROWS),
        .NUM_COLS (NUM_COLS)
    ) u_cursor (
        .clk           (clk),
        .rst           (rst),
        .op            (cur_op),
        .row           (cursor_row),
        .col           (cursor_col),
        .scroll_needed (scroll_needed),
        .at_last_col   (at_last_col),
        .addr          (cur_addr)
    );

    // State and sequence registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            idx           <= '0;
            ch            <= '0;
            adv           <= 1'b0;
            clear_pending <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            ch            <= ch_n;
            adv           <= adv_n;
            clear_pending <= clear_pending_n;
        end
    end

    // Next-state, cursor operation and write-step decode from registered state.
    always_comb begin
        state_n         = state;
        idx_n           = idx;
        ch_n            = ch;
        adv_n           = adv;
        clear_pending_n = clear_pending;
        clear_done      = 1'b0;
        cur_op          = CUR_NONE;
        step_we         = 1'b0;
        step_waddr      = '0;
        step_wdata      = '0;
        step_raddr      = '0;

        case (state)
            ST_IDLE: begin
                if (clear_pending || clear_req) begin
                    state_n = ST_CLEAR;
                    idx_n   = '0;
                end else if (accept) begin
                    if (is_printable(in_data)) begin
                        ch_n    = in_data[CHAR_W-1:0];
                        adv_n   = 1'b1;
                        state_n = ST_WRITE;
                    end else begin
                        case (in_data)
                            CH_LF: begin
                                if (scroll_needed) begin
                                    cur_op  = CUR_CR;
                                    state_n = ST_SCROLL_COPY;
                                    idx_n   = '0;
                                end else begin
                                    cur_op = CUR_NEWLINE;
                                end
                            end
                            CH_CR: cur_op = CUR_CR;
                            CH_BS: begin
                                if (cursor_col != '0) begin
                                    cur_op  = CUR_BACK;
                                    ch_n    = BLANK_CHAR;
                                    adv_n   = 1'b0;
                                    state_n = ST_WRITE;
                                end
                            end
                            CH_FF: begin
                                state_n = ST_CLEAR;
                                idx_n   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            ST_WRITE: begin
                step_we    = step_ok;
                step_waddr = cur_addr;
                step_wdata = ch;
                if (step_ok) begin
                    state_n = ST_IDLE;
                    if (adv) begin
                        cur_op = CUR_ADVANCE;
                        if (at_last_col && scroll_needed) begin
                            state_n = ST_SCROLL_COPY;
                            idx_n   = '0;
                        end
                    end
                end
            end

            ST_SCROLL_COPY: begin
                step_raddr = idx + ROW_STRIDE;
                step_we    = step_ok;
                step_waddr = idx;
                step_wdata = buf_rdata;
                if (step_ok) begin
                    if (idx == COPY_LAST) begin
                        state_n = ST_SCROLL_FILL;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + ADDR_W'(1);
                    end
                end
            end

            ST_SCROLL_FILL: begin
                step_we    = step_ok;
                step_waddr = FILL_BASE + idx;
                step_wdata = BLANK_CHAR;
                if (step_ok) begin
                    if (idx == FILL_LAST) begin
                        state_n = ST_IDLE;
                        idx_n   = '0;
                        cur_op  = CUR_BOTTOM;
                    end else begin
                        idx_n = idx + ADDR_W'(1);
                    end
                end
            end

            ST_CLEAR: begin
                step_we    = step_ok;
                step_waddr = idx;
                step_wdata = BLANK_CHAR;
                if (step_ok) begin
                    if (idx == CLEAR_LAST) begin
                        state_n    = ST_IDLE;
                        idx_n      = '0;
                        cur_op     = CUR_HOME;
                        clear_done = 1'b1;
                    end else begin
                        idx_n = idx + ADDR_W'(1);
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
                idx_n   = '0;
            end
        endcase

        // A clear request that arrives mid-sequence is remembered until the next IDLE.
        if (clear_done) clear_pending_n = 1'b0;
        if (clear_req && (state != ST_IDLE)) clear_pending_n = 1'b1;
    end

    // CPU writes always win the buffer write port.
    assign buf_we    = host_we | step_we;
    assign buf_waddr = host_we ? host_addr : step_waddr;
    assign buf_wdata = host_we ? host_data : step_wdata;
    assign buf_raddr = step_raddr;

endmodule
